signal_snapshot_buffer: RTL and testbench
=========================================

# signal_snapshot_buffer

Buffers snapshots of a packed vector of probed signals, each tagged with a cycle stamp, in a first-word-fall-through FIFO. It sits directly upstream of the DPI exporter tick call. The per-cycle sampling point pushes the exported signal vector in, and the tick side drains entries through a valid/ready handshake. This decouples the consumer's pace from the design clock without silently losing information: every drop is counted. An optional change-only mode suppresses pushes of repeated values.

## Interface
- `WIDTH`, default 7: bit width of the sampled signal vector.
- `DEPTH`, default 8: FIFO entries. Must be a power of two, ≥ 2.
- `STAMP_W`, default 16: width of the free-running cycle stamp.
- `clock` in 1: single clock. All state changes on its rising edge.
- `reset` in 1: asynchronous, active-high. Clears all state immediately.
- `sample_en` in 1: sample request for this cycle.
- `sample_data` in `WIDTH`: vector to capture.
- `change_only` in 1: 1 means push only when `sample_data` differs from the last observed sample.
- `out_valid` out 1: head entry present (equals not empty).
- `out_ready` in 1: consumer accepts the head entry this cycle.
- `out_data` out `WIDTH`: head entry data.
- `out_stamp` out `STAMP_W`: cycle stamp of the head entry.
- `count` out `$clog2(DEPTH+1)`: number of occupied entries.
- `full` out 1: `count == DEPTH`.
- `drop_count` out 16: saturating count of rejected pushes.

## Operation
- **Cycle stamp**
  - `stamp` starts at 0 after reset and increments every cycle.
  - It wraps from 2^STAMP_W−1 to 0.
  - An entry records the `stamp` value of its capture cycle.
- **Push candidate**
  - A candidate exists when `sample_en && (!change_only || !have_last || sample_data != last_value)`.
  - On every candidate, `last_value` is set to `sample_data` and `have_last` is set to 1, whether or not the push is accepted.
  - Reset clears `have_last`, so the first sample after reset is always a candidate.
- **Push accept:** a candidate is accepted if `!full`, or if `full && out_valid && out_ready` (pop in the same cycle frees a slot).
- **Drop:** a candidate that is not accepted increments `drop_count`, saturating at 0xFFFF.
- **Pop:** occurs when `out_valid && out_ready`. `out_ready` while empty has no effect.
- **Simultaneous push and pop**
  - `count` is unchanged.
  - Ordering is preserved: the popped entry is the old head, and the new entry goes to the tail.
- **Storage and pointers**
  - Storage is a circular buffer with `log2(DEPTH)`-bit read and write pointers that wrap naturally.
  - `count` is tracked explicitly; full and empty are derived from it.
- **Head outputs:** `out_data` and `out_stamp` are driven combinationally from the read-pointer entry. When empty they are don't-care, but the implementation holds them at the last head value (no X).
- **Reset values:** `count` = 0, `out_valid` = 0, `full` = 0, `drop_count` = 0, `stamp` = 0, pointers = 0, `have_last` = 0. Storage contents are not reset.

## Timing
- **Push-to-visibility latency:** 1 cycle. A sample accepted at edge N makes `out_valid` high after edge N, with `out_data`/`out_stamp` showing the captured value and stamp N.
- **Pop:** takes effect at the edge where `out_valid && out_ready`. The next head (or `out_valid` = 0) appears after that edge.
- **Throughput:** 1 push and 1 pop per cycle sustained, including at full and at empty.
- **Empty with a push in the same cycle:** there is no bypass. `out_valid` stays 0 that cycle and rises the next cycle.
- **Combinational paths:** `out_ready` affects only next-state logic. There is no combinational path from `out_ready` to `out_valid`, `out_data` or `full`.
- **Reset mid-operation**
  - Asserting `reset` asynchronously drops all entries: `out_valid` falls without waiting for a clock edge.
  - After deassertion, operation resumes at the first rising edge, with `stamp` = 0 at that edge.
- **Counter wrap:** `stamp` wrap is not an event. Entries straddling the wrap keep their raw values.

## Test plan
- **Basic FIFO order:** DEPTH=8, `change_only`=0, `out_ready`=0. Push 0x01..0x05 on consecutive cycles from stamp 0 → `count`=5. Then set `out_ready`=1 → data 0x01..0x05 emerge in order with stamps 0..4, and `count` returns to 0.
- **Overflow with drops:** push 10 samples with `out_ready`=0 → `full`=1 after 8, `drop_count`=2, and the FIFO holds samples 1–8 exactly.
- **Full with simultaneous pop:** at `full`, push 0x7F with `out_ready`=1 → push accepted, `count` stays 8, `drop_count` unchanged, and 0x7F is read last.
- **Change-only mode:** `change_only`=1, `sample_en`=1, sample sequence 0x3,0x3,0x3,0x5,0x5,0x3 → exactly 3 entries (0x3, 0x5, 0x3) with stamps of the cycles where each value first appeared.
- **Reset mid-stream:** 4 entries queued, assert `reset` between edges → `out_valid`=0 and `count`=0 immediately. After release with `change_only`=1 and the same data as before reset → first sample is pushed with stamp 0.
- **Saturation and wrap:** STAMP_W=4 with continuous push/pop for 20 cycles → stamps go 0..15, 0..3. Force 0x10005 candidates while full → `drop_count` holds at 0xFFFF.

Source files
------------

// File: rtl/signal_snapshot_buffer.sv
// Snapshot FIFO: captures a probed signal vector with a free-running cycle stamp
// and hands entries to a slower consumer, counting every push it cannot accept.
module signal_snapshot_buffer #(
    parameter int WIDTH   = 7,
    parameter int DEPTH   = 8,
    parameter int STAMP_W = 16
) (
    input  logic                         clock,
    input  logic                         reset,
    input  logic                         sample_en,
    input  logic [WIDTH-1:0]             sample_data,
    input  logic                         change_only,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [WIDTH-1:0]             out_data,
    output logic [STAMP_W-1:0]           out_stamp,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full,
    output logic [15:0]                  drop_count
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(DEPTH+1);
    localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0]   data_mem  [DEPTH];
    logic [STAMP_W-1:0] stamp_mem [DEPTH];

    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic [STAMP_W-1:0] stamp_q, stamp_d;
    logic [15:0]        drop_q, drop_d;
    logic [WIDTH-1:0]   last_value_q, last_value_d;
    logic               have_last_q, have_last_d;
    logic [WIDTH-1:0]   hold_data_q, hold_data_d;
    logic [STAMP_W-1:0] hold_stamp_q, hold_stamp_d;

    logic empty;
    logic is_full;
    logic candidate;
    logic push;
    logic pop;
    logic drop;

    // Handshake: an entry transfers on a rising edge where out_valid && out_ready.
    // out_valid depends only on registered occupancy, never on out_ready.
    assign empty   = (count_q == '0);
    assign is_full = (count_q == FULL_COUNT);

    assign candidate = sample_en &&
                       (!change_only || !have_last_q || (sample_data != last_value_q));
    assign pop       = !empty && out_ready;
    assign push      = candidate && (!is_full || pop);
    assign drop      = candidate && !push;

    always_comb begin
        rd_ptr_d     = rd_ptr_q;
        wr_ptr_d     = wr_ptr_q;
        count_d      = count_q;
        stamp_d      = stamp_q + STAMP_W'(1);
        drop_d       = drop_q;
        last_value_d = last_value_q;
        have_last_d  = have_last_q;
        hold_data_d  = hold_data_q;
        hold_stamp_d = hold_stamp_q;

        if (candidate) begin
            last_value_d = sample_data;
            have_last_d  = 1'b1;
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
        end

        if (pop) begin
            rd_ptr_d     = rd_ptr_q + PTR_W'(1);
            hold_data_d  = data_mem[rd_ptr_q];
            hold_stamp_d = stamp_mem[rd_ptr_q];
        end

        case ({push, pop})
            2'b10:   count_d = count_q + CNT_W'(1);
            2'b01:   count_d = count_q - CNT_W'(1);
            default: count_d = count_q;
        endcase

        if (drop && (drop_q != 16'hFFFF)) begin
            drop_d = drop_q + 16'd1;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            stamp_q      <= '0;
            drop_q       <= '0;
            last_value_q <= '0;
            have_last_q  <= 1'b0;
            hold_data_q  <= '0;
            hold_stamp_q <= '0;
        end else begin
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            stamp_q      <= stamp_d;
            drop_q       <= drop_d;
            last_value_q <= last_value_d;
            have_last_q  <= have_last_d;
            hold_data_q  <= hold_data_d;
            hold_stamp_q <= hold_stamp_d;
        end
    end

    // Storage is deliberately left out of reset; occupancy guards every read.
    always_ff @(posedge clock) begin
        if (push) begin
            data_mem[wr_ptr_q]  <= sample_data;
            stamp_mem[wr_ptr_q] <= stamp_q;
        end
    end

    // While empty, the head shows the last entry popped so the outputs never go X.
    assign out_valid  = !empty;
    assign out_data   = empty ? hold_data_q  : data_mem[rd_ptr_q];
    assign out_stamp  = empty ? hold_stamp_q : stamp_mem[rd_ptr_q];
    assign count      = count_q;
    assign full       = is_full;
    assign drop_count = drop_q;

endmodule

// File: tb/tb_signal_snapshot_buffer.sv
// Directed bench for signal_snapshot_buffer: a vector table for the main FIFO
// behaviour plus hand-written sequences for reset, stamp wrap and drop saturation.
module tb_signal_snapshot_buffer;

  logic        clk;
  logic        rst;
  logic        en;
  logic [6:0]  din;
  logic        chg;
  logic        rdy;
  logic        vld;
  logic [6:0]  dout;
  logic [15:0] stmp;
  logic [3:0]  cnt;
  logic        ful;
  logic [15:0] drp;

  logic        rst2;
  logic        en2;
  logic [6:0]  din2;
  logic        chg2;
  logic        rdy2;
  logic        vld2;
  logic [6:0]  dout2;
  logic [3:0]  stmp2;
  logic [1:0]  cnt2;
  logic        ful2;
  logic [15:0] drp2;

  int total;
  int bad;

  signal_snapshot_buffer #(.WIDTH(7), .DEPTH(8), .STAMP_W(16)) dut (
    .clock(clk), .reset(rst), .sample_en(en), .sample_data(din),
    .change_only(chg), .out_valid(vld), .out_ready(rdy), .out_data(dout),
    .out_stamp(stmp), .count(cnt), .full(ful), .drop_count(drp)
  );

  signal_snapshot_buffer #(.WIDTH(7), .DEPTH(2), .STAMP_W(4)) dut2 (
    .clock(clk), .reset(rst2), .sample_en(en2), .sample_data(din2),
    .change_only(chg2), .out_valid(vld2), .out_ready(rdy2), .out_data(dout2),
    .out_stamp(stmp2), .count(cnt2), .full(ful2), .drop_count(drp2)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic        en;
    logic [6:0]  data;
    logic        chg;
    logic        rdy;
    logic        e_valid;
    logic [6:0]  e_data;
    logic [15:0] e_stamp;
    logic [3:0]  e_count;
    logic        e_full;
    logic [15:0] e_drop;
  } vec_t;

  vec_t vecs[$];

  task automatic add(input logic e, input logic [6:0] d, input logic c, input logic r,
                     input logic ev, input logic [6:0] ed, input logic [15:0] es,
                     input logic [3:0] ec, input logic ef, input logic [15:0] edr);
    vec_t v;
    v.en = e; v.data = d; v.chg = c; v.rdy = r;
    v.e_valid = ev; v.e_data = ed; v.e_stamp = es;
    v.e_count = ec; v.e_full = ef; v.e_drop = edr;
    vecs.push_back(v);
  endtask

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst = 1'b1; en = 1'b0; din = '0; chg = 1'b0; rdy = 1'b0;
    rst2 = 1'b1; en2 = 1'b0; din2 = '0; chg2 = 1'b0; rdy2 = 1'b0;

    // Row index equals the stamp of the edge it is applied at.
    // Basic order: push 1..5, then drain.
    add(1, 7'h01, 0, 0, 1, 7'h01, 16'd0, 4'd1, 0, 16'd0);
    add(1, 7'h02, 0, 0, 1, 7'h01, 16'd0, 4'd2, 0, 16'd0);
    add(1, 7'h03, 0, 0, 1, 7'h01, 16'd0, 4'd3, 0, 16'd0);
    add(1, 7'h04, 0, 0, 1, 7'h01, 16'd0, 4'd4, 0, 16'd0);
    add(1, 7'h05, 0, 0, 1, 7'h01, 16'd0, 4'd5, 0, 16'd0);
    add(0, 7'h00, 0, 1, 1, 7'h02, 16'd1, 4'd4, 0, 16'd0);
    add(0, 7'h00, 0, 1, 1, 7'h03, 16'd2, 4'd3, 0, 16'd0);
    add(0, 7'h00, 0, 1, 1, 7'h04, 16'd3, 4'd2, 0, 16'd0);
    add(0, 7'h00, 0, 1, 1, 7'h05, 16'd4, 4'd1, 0, 16'd0);
    add(0, 7'h00, 0, 1, 0, 7'h05, 16'd4, 4'd0, 0, 16'd0);
    // Overflow: 10 pushes into 8 slots.
    add(1, 7'h11, 0, 0, 1, 7'h11, 16'd10, 4'd1, 0, 16'd0);
    add(1, 7'h12, 0, 0, 1, 7'h11, 16'd10, 4'd2, 0, 16'd0);
    add(1, 7'h13, 0, 0, 1, 7'h11, 16'd10, 4'd3, 0, 16'd0);
    add(1, 7'h14, 0, 0, 1, 7'h11, 16'd10, 4'd4, 0, 16'd0);
    add(1, 7'h15, 0, 0, 1, 7'h11, 16'd10, 4'd5, 0, 16'd0);
    add(1, 7'h16, 0, 0, 1, 7'h11, 16'd10, 4'd6, 0, 16'd0);
    add(1, 7'h17, 0, 0, 1, 7'h11, 16'd10, 4'd7, 0, 16'd0);
    add(1, 7'h18, 0, 0, 1, 7'h11, 16'd10, 4'd8, 1, 16'd0);
    add(1, 7'h19, 0, 0, 1, 7'h11, 16'd10, 4'd8, 1, 16'd1);
    add(1, 7'h1A, 0, 0, 1, 7'h11, 16'd10, 4'd8, 1, 16'd2);
    // Push at full with a simultaneous pop.
    add(1, 7'h7F, 0, 1, 1, 7'h12, 16'd11, 4'd8, 1, 16'd2);
    add(0, 7'h00, 0, 1, 1, 7'h13, 16'd12, 4'd7, 0, 16'd2);
    add(0, 7'h00, 0, 1, 1, 7'h14, 16'd13, 4'd6, 0, 16'd2);
    add(0, 7'h00, 0, 1, 1, 7'h15, 16'd14, 4'd5, 0, 16'd2);
    add(0, 7'h00, 0, 1, 1, 7'h16, 16'd15, 4'd4, 0, 16'd2);
    add(0, 7'h00, 0, 1, 1, 7'h17, 16'd16, 4'd3, 0, 16'd2);
    add(0, 7'h00, 0, 1, 1, 7'h18, 16'd17, 4'd2, 0, 16'd2);
    add(0, 7'h00, 0, 1, 1, 7'h7F, 16'd20, 4'd1, 0, 16'd2);
    add(0, 7'h00, 0, 1, 0, 7'h7F, 16'd20, 4'd0, 0, 16'd2);
    // Change-only: 3,3,3,5,5,3 keeps three entries.
    add(1, 7'h03, 1, 0, 1, 7'h03, 16'd29, 4'd1, 0, 16'd2);
    add(1, 7'h03, 1, 0, 1, 7'h03, 16'd29, 4'd1, 0, 16'd2);
    add(1, 7'h03, 1, 0, 1, 7'h03, 16'd29, 4'd1, 0, 16'd2);
    add(1, 7'h05, 1, 0, 1, 7'h03, 16'd29, 4'd2, 0, 16'd2);
    add(1, 7'h05, 1, 0, 1, 7'h03, 16'd29, 4'd2, 0, 16'd2);
    add(1, 7'h03, 1, 0, 1, 7'h03, 16'd29, 4'd3, 0, 16'd2);
    add(0, 7'h00, 1, 1, 1, 7'h05, 16'd32, 4'd2, 0, 16'd2);
    add(0, 7'h00, 1, 1, 1, 7'h03, 16'd34, 4'd1, 0, 16'd2);
    add(0, 7'h00, 1, 1, 0, 7'h03, 16'd34, 4'd0, 0, 16'd2);

    repeat (2) @(posedge clk);
    #1;
    chk("reset_valid", 32'(vld), 32'd0);
    chk("reset_count", 32'(cnt), 32'd0);
    chk("reset_full",  32'(ful), 32'd0);
    chk("reset_drop",  32'(drp), 32'd0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      en  = vecs[i].en;
      din = vecs[i].data;
      chg = vecs[i].chg;
      rdy = vecs[i].rdy;
      @(posedge clk);
      #1;
      chk($sformatf("vec%0d_valid", i), 32'(vld),  32'(vecs[i].e_valid));
      chk($sformatf("vec%0d_data", i),  32'(dout), 32'(vecs[i].e_data));
      chk($sformatf("vec%0d_stamp", i), 32'(stmp), 32'(vecs[i].e_stamp));
      chk($sformatf("vec%0d_count", i), 32'(cnt),  32'(vecs[i].e_count));
      chk($sformatf("vec%0d_full", i),  32'(ful),  32'(vecs[i].e_full));
      chk($sformatf("vec%0d_drop", i),  32'(drp),  32'(vecs[i].e_drop));
    end

    // Reset mid-stream with four entries queued.
    en = 1'b1; chg = 1'b1; rdy = 1'b0;
    for (int k = 0; k < 4; k++) begin
      din = 7'h2A + 7'(k);
      @(posedge clk);
      #1;
    end
    chk("pre_reset_count", 32'(cnt), 32'd4);
    en = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("midreset_valid", 32'(vld), 32'd0);
    chk("midreset_count", 32'(cnt), 32'd0);
    chk("midreset_full",  32'(ful), 32'd0);
    chk("midreset_drop",  32'(drp), 32'd0);
    en = 1'b1; din = 7'h2D; chg = 1'b1;
    #1;
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("post_reset_valid", 32'(vld),  32'd1);
    chk("post_reset_data",  32'(dout), 32'h2D);
    chk("post_reset_stamp", 32'(stmp), 32'd0);
    chk("post_reset_count", 32'(cnt),  32'd1);
    en = 1'b0;

    // Small instance: continuous push/pop across the 4-bit stamp wrap.
    rst2 = 1'b0; en2 = 1'b1; chg2 = 1'b0; rdy2 = 1'b1;
    for (int k = 0; k < 20; k++) begin
      din2 = 7'(k);
      @(posedge clk);
      #1;
      chk($sformatf("wrap%0d_stamp", k), 32'(stmp2), 32'(k % 16));
      chk($sformatf("wrap%0d_data", k),  32'(dout2), 32'(k));
      chk($sformatf("wrap%0d_count", k), 32'(cnt2),  32'd1);
    end

    // Fill, then hammer with candidates that must all be dropped.
    rdy2 = 1'b0; din2 = 7'h55;
    @(posedge clk);
    #1;
    chk("sat_fill_full",  32'(ful2),  32'd1);
    chk("sat_fill_count", 32'(cnt2),  32'd2);
    chk("sat_fill_drop",  32'(drp2),  32'd0);
    chk("sat_head_data",  32'(dout2), 32'd19);
    chk("sat_head_stamp", 32'(stmp2), 32'd3);
    repeat (10) @(posedge clk);
    #1;
    chk("sat_drop10", 32'(drp2), 32'd10);
    repeat (32'h10005 - 10) @(posedge clk);
    #1;
    chk("sat_drop_max",   32'(drp2),  32'hFFFF);
    chk("sat_end_count",  32'(cnt2),  32'd2);
    chk("sat_end_head",   32'(dout2), 32'd19);
    en2 = 1'b0;

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
